// File: rtl/move_if.sv
// move_if: command handshake, map read port, fog write port and status of move_controller
interface move_if;
  logic        cmd_valid;
  logic [1:0]  cmd_dir;
  logic        cmd_ready;
  logic        map_re;
  logic [15:0] map_addr;
  logic [15:0] map_rdata;
  logic        fog_we;
  logic [15:0] fog_addr;
  logic [15:0] cur_pos;
  logic        move_ok;
  logic        move_blocked;
  logic        render_req;
  logic        exit_reached;
  modport master (
    input  cmd_valid, cmd_dir, map_rdata,
    output cmd_ready, map_re, map_addr, fog_we, fog_addr, cur_pos,
           move_ok, move_blocked, render_req, exit_reached
  );
  modport slave (
    output cmd_valid, cmd_dir, map_rdata,
    input  cmd_ready, map_re, map_addr, fog_we, fog_addr, cur_pos,
           move_ok, move_blocked, render_req, exit_reached
  );
endinterface

// File: rtl/move_controller.sv
// move_controller: one-step move sequencer with map read, fog reveal and render request.
// Define DIAG_REVEAL_EN to add the four diagonal reveal slots.
module move_controller #(
  parameter int MAP_W     = 10,
  parameter int MAP_H     = 10,
  parameter int START_POS = 50,
  parameter int EXIT_POS  = 59,
  parameter int WALL_ID   = 5
) (
  input logic    clk,
  input logic    rst_n,
  move_if.master bus
);
`ifdef DIAG_REVEAL_EN
  localparam int SW = 3;
`else
  localparam int SW = 2;
`endif
  localparam logic [15:0] W  = 16'(MAP_W);
  localparam logic [15:0] N  = 16'(MAP_W * MAP_H);
  localparam logic [15:0] EX = 16'(EXIT_POS);
  typedef enum logic [2:0] {INIT_REVEAL, IDLE, READ, EVAL, REVEAL, RENDER, DONE} state_t;
  state_t state, state_n;
  logic live, reveal, wall, nb_ok, ok_q, blk_q, exit_q;
  logic [SW-1:0] slot;
  logic [15:0] pos, target, nb;
  logic [3:0] lg;
  function automatic logic [3:0] legal4(input logic [15:0] p);
    return {p % W != W - 16'd1, p % W != '0, p + W < N, p >= W};
  endfunction
  function automatic logic [15:0] step(input logic [15:0] p, input logic [1:0] d);
    return d[1] ? (d[0] ? p + 16'd1 : p - 16'd1) : (d[0] ? p + W : p - W);
  endfunction
  always_comb begin
    lg   = legal4(pos);
    wall = bus.map_rdata == 16'(WALL_ID);
`ifdef DIAG_REVEAL_EN
    nb_ok = slot[2] ? lg[{1'b0, slot[1]}] && lg[{1'b1, slot[0]}] : lg[slot[1:0]];
    nb    = slot[2] ? step(step(pos, {1'b0, slot[1]}), {1'b1, slot[0]}) : step(pos, slot[1:0]);
`else
    nb_ok = lg[slot];
    nb    = step(pos, slot);
`endif
  end
  always_comb begin
    state_n = state;
    case (state)
      INIT_REVEAL, REVEAL: state_n = live && &slot ? RENDER : state;
      IDLE:                state_n = bus.cmd_valid && lg[bus.cmd_dir] ? READ : IDLE;
      READ:                state_n = EVAL;
      EVAL:                state_n = wall ? IDLE : REVEAL;
      RENDER:              state_n = pos == EX ? DONE : IDLE;
      default:             state_n = state;
    endcase
  end
  // live holds off the first reveal slot until the cycle after reset is released
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= INIT_REVEAL;
      live   <= 1'b0;
      slot   <= '0;
      pos    <= 16'(START_POS);
      target <= '0;
      ok_q   <= 1'b0;
      blk_q  <= 1'b0;
      exit_q <= 1'b0;
    end else begin
      state <= state_n;
      live  <= 1'b1;
      slot  <= live && (state == INIT_REVEAL || state == REVEAL) ? slot + 1'b1 : '0;
      ok_q  <= state == EVAL && !wall;
      blk_q <= (state == IDLE && bus.cmd_valid && !lg[bus.cmd_dir]) || (state == EVAL && wall);
      if (state == IDLE && bus.cmd_valid) target <= step(pos, bus.cmd_dir);
      if (state == EVAL && !wall) pos <= target;
      if (state == RENDER && pos == EX) exit_q <= 1'b1;
    end
  end
  always_comb begin
    reveal           = live && (state == INIT_REVEAL || state == REVEAL);
    bus.cmd_ready    = state == IDLE;
    bus.map_re       = state == READ;
    bus.map_addr     = state == READ ? target : '0;
    bus.fog_we       = reveal && nb_ok;
    bus.fog_addr     = reveal && nb_ok ? nb : '0;
    bus.cur_pos      = pos;
    bus.move_ok      = ok_q;
    bus.move_blocked = blk_q;
    bus.render_req   = state == RENDER;
    bus.exit_reached = exit_q;
  end
endmodule
